// File: rtl/axis_priority_demux.sv
// Steers each AXI-Stream packet, whole, to one of three registered priority
// outputs chosen by a 2-bit field in its first beat, or drops it and counts it.
module axis_priority_demux #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PRIO_OFFSET     = 0,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,

    output logic [AXIS_DATA_WIDTH-1:0] m_axis_priority_fifo0_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_priority_fifo0_tkeep,
    output logic                       m_axis_priority_fifo0_tvalid,
    input  logic                       m_axis_priority_fifo0_tready,
    output logic                       m_axis_priority_fifo0_tlast,

    output logic [AXIS_DATA_WIDTH-1:0] m_axis_priority_fifo1_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_priority_fifo1_tkeep,
    output logic                       m_axis_priority_fifo1_tvalid,
    input  logic                       m_axis_priority_fifo1_tready,
    output logic                       m_axis_priority_fifo1_tlast,

    output logic [AXIS_DATA_WIDTH-1:0] m_axis_priority_fifo2_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_priority_fifo2_tkeep,
    output logic                       m_axis_priority_fifo2_tvalid,
    input  logic                       m_axis_priority_fifo2_tready,
    output logic                       m_axis_priority_fifo2_tlast,

    output logic [CNT_WIDTH-1:0]       drop_count
);

    typedef enum logic [1:0] {HEAD, FWD, DROP} state_t;

    state_t                     state;
    logic [1:0]                 route;
    logic [1:0]                 prio;
    logic [1:0]                 target;
    logic                       xfer;
    logic [2:0]                 load;
    logic [2:0]                 out_ready;
    logic [3:0]                 free;

    logic [2:0]                 out_valid;
    logic [AXIS_DATA_WIDTH-1:0] out_data [3];
    logic [AXIS_KEEP_WIDTH-1:0] out_keep [3];
    logic [2:0]                 out_last;

    assign prio      = s_axis_tdata[PRIO_OFFSET+1:PRIO_OFFSET];
    assign out_ready = {m_axis_priority_fifo2_tready, m_axis_priority_fifo1_tready,
                        m_axis_priority_fifo0_tready};
    // Entry 3 (the drop code) is never a real output, so it is never free.
    assign free      = {1'b0, ~out_valid | out_ready};
    assign xfer      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        target        = (state == HEAD) ? prio : route;
        s_axis_tready = 1'b0;
        case (state)
            HEAD:    s_axis_tready = s_axis_tvalid && (prio == 2'd3 || free[prio]);
            FWD:     s_axis_tready = free[route];
            DROP:    s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
        for (int n = 0; n < 3; n++) begin
            load[n] = xfer && (state != DROP) && (target == 2'(n));
        end
    end

    // Packet framing: the route is latched on the header and held until tlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HEAD;
            route      <= 2'd0;
            drop_count <= '0;
        end else if (xfer) begin
            case (state)
                HEAD: begin
                    if (prio == 2'd3) begin
                        if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
                        if (!s_axis_tlast) state <= DROP;
                    end else if (!s_axis_tlast) begin
                        route <= prio;
                        state <= FWD;
                    end
                end
                FWD, DROP: if (s_axis_tlast) state <= HEAD;
                default:   state <= HEAD;
            endcase
        end
    end

    // One skid-free register per output; a load wins over a drain in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_last  <= '0;
            for (int n = 0; n < 3; n++) begin
                out_data[n] <= '0;
                out_keep[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (load[n]) begin
                    out_valid[n] <= 1'b1;
                    out_data[n]  <= s_axis_tdata;
                    out_keep[n]  <= s_axis_tkeep;
                    out_last[n]  <= s_axis_tlast;
                end else if (out_ready[n]) begin
                    out_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign m_axis_priority_fifo0_tdata  = out_data[0];
    assign m_axis_priority_fifo0_tkeep  = out_keep[0];
    assign m_axis_priority_fifo0_tvalid = out_valid[0];
    assign m_axis_priority_fifo0_tlast  = out_last[0];

    assign m_axis_priority_fifo1_tdata  = out_data[1];
    assign m_axis_priority_fifo1_tkeep  = out_keep[1];
    assign m_axis_priority_fifo1_tvalid = out_valid[1];
    assign m_axis_priority_fifo1_tlast  = out_last[1];

    assign m_axis_priority_fifo2_tdata  = out_data[2];
    assign m_axis_priority_fifo2_tkeep  = out_keep[2];
    assign m_axis_priority_fifo2_tvalid = out_valid[2];
    assign m_axis_priority_fifo2_tlast  = out_last[2];

endmodule

// File: tb/tb_axis_priority_demux.sv
// Randomized bench for axis_priority_demux: packets are scored against per-output
// expected beat queues and a saturating drop tally built from the packet headers.
module tb_axis_priority_demux;

    localparam int CNT_W    = 4;
    localparam int DROP_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic             clk;
    logic             rst;
    logic [63:0]      s_tdata;
    logic [7:0]       s_tkeep;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [63:0]      m0_tdata, m1_tdata, m2_tdata;
    logic [7:0]       m0_tkeep, m1_tkeep, m2_tkeep;
    logic             m0_tvalid, m1_tvalid, m2_tvalid;
    logic             m0_tlast, m1_tlast, m2_tlast;
    logic [2:0]       m_ready;
    logic [CNT_W-1:0] drop_count;

    logic [2:0]       m_valid;
    beat_t            m_beat [3];

    beat_t            exp_q [3][$];
    int               drop_exp;
    int               n_checks;
    int               n_errors;
    int               mode;
    bit               mon_en;
    bit               drop_watch;
    logic [1:0]       cur_tgt;

    axis_priority_demux #(
        .AXIS_DATA_WIDTH(64),
        .AXIS_KEEP_WIDTH(8),
        .PRIO_OFFSET(0),
        .CNT_WIDTH(CNT_W)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .s_axis_tdata                 (s_tdata),
        .s_axis_tkeep                 (s_tkeep),
        .s_axis_tvalid                (s_tvalid),
        .s_axis_tready                (s_tready),
        .s_axis_tlast                 (s_tlast),
        .m_axis_priority_fifo0_tdata  (m0_tdata),
        .m_axis_priority_fifo0_tkeep  (m0_tkeep),
        .m_axis_priority_fifo0_tvalid (m0_tvalid),
        .m_axis_priority_fifo0_tready (m_ready[0]),
        .m_axis_priority_fifo0_tlast  (m0_tlast),
        .m_axis_priority_fifo1_tdata  (m1_tdata),
        .m_axis_priority_fifo1_tkeep  (m1_tkeep),
        .m_axis_priority_fifo1_tvalid (m1_tvalid),
        .m_axis_priority_fifo1_tready (m_ready[1]),
        .m_axis_priority_fifo1_tlast  (m1_tlast),
        .m_axis_priority_fifo2_tdata  (m2_tdata),
        .m_axis_priority_fifo2_tkeep  (m2_tkeep),
        .m_axis_priority_fifo2_tvalid (m2_tvalid),
        .m_axis_priority_fifo2_tready (m_ready[2]),
        .m_axis_priority_fifo2_tlast  (m2_tlast),
        .drop_count                   (drop_count)
    );

    assign m_valid   = {m2_tvalid, m1_tvalid, m0_tvalid};
    assign m_beat[0] = {m0_tdata, m0_tkeep, m0_tlast};
    assign m_beat[1] = {m1_tdata, m1_tkeep, m1_tlast};
    assign m_beat[2] = {m2_tdata, m2_tkeep, m2_tlast};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream readiness: 0 = all ready, 1 = random, 2 = fifo0 stalled.
    initial begin
        m_ready = 3'b111;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       m_ready = 3'b111;
                1:       m_ready = 3'($urandom_range(0, 7));
                default: m_ready = 3'b110;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, actual, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input beat_t actual, input beat_t expected);
        checkOutput({tag, "_data"}, actual.d, expected.d);
        checkOutput({tag, "_keep_last"}, 64'({actual.k, actual.l}), 64'({expected.k, expected.l}));
    endtask

    // Output scoreboard, hold-stability and one-cycle-latency checks, all at negedge.
    initial begin
        bit         pend_valid;
        logic [1:0] pend_tgt;
        logic [63:0] pend_data;
        bit [2:0]   hold_valid;
        beat_t      hold_beat [3];
        beat_t      e;
        pend_valid = 1'b0;
        pend_tgt   = 2'd0;
        pend_data  = '0;
        hold_valid = '0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                pend_valid = 1'b0;
                hold_valid = '0;
            end else begin
                if (pend_valid) begin
                    checkOutput("latency_valid", 64'(m_valid[pend_tgt]), 64'd1);
                    checkOutput("latency_data", m_beat[pend_tgt].d, pend_data);
                    pend_valid = 1'b0;
                end
                for (int n = 0; n < 3; n++) begin
                    if (hold_valid[n] && m_valid[n])
                        checkBeat($sformatf("fifo%0d_hold", n), m_beat[n], hold_beat[n]);
                    hold_valid[n] = 1'b0;
                    if (m_valid[n] && m_ready[n]) begin
                        if (exp_q[n].size() == 0) begin
                            checkOutput($sformatf("fifo%0d_unexpected_beat", n), 64'(m_valid[n]), 64'd0);
                        end else begin
                            e = exp_q[n].pop_front();
                            checkBeat($sformatf("fifo%0d_beat", n), m_beat[n], e);
                        end
                    end else if (m_valid[n]) begin
                        hold_valid[n] = 1'b1;
                        hold_beat[n]  = m_beat[n];
                    end
                end
                if (drop_watch)
                    checkOutput("drop_no_valid", 64'(m_valid), 64'd0);
                if (s_tvalid && s_tready && cur_tgt != 2'd3) begin
                    pend_valid = 1'b1;
                    pend_tgt   = cur_tgt;
                    pend_data  = s_tdata;
                end
            end
        end
    end

    // Sends one packet and records what the outputs must eventually show.
    task automatic applyStimulus(input logic [1:0] p, input int nbeats, input int gap_max, input bit no_stall);
        beat_t b;
        int    waited;
        int    g;
        if (p == 2'd3) drop_exp = (drop_exp == DROP_MAX) ? DROP_MAX : drop_exp + 1;
        cur_tgt = p;
        for (int i = 0; i < nbeats; i++) begin
            b.d = {$urandom, $urandom};
            if (i == 0) b.d[1:0] = p;
            b.k = 8'($urandom);
            b.l = (i == nbeats - 1);
            if (p != 2'd3) exp_q[p].push_back(b);
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (g > 0) begin
                s_tvalid = 1'b0;
                repeat (g) @(posedge clk);
                #1;
            end
            s_tdata  = b.d;
            s_tkeep  = b.k;
            s_tlast  = b.l;
            s_tvalid = 1'b1;
            waited   = 0;
            @(negedge clk);
            while (!s_tready && waited < 300) begin
                @(negedge clk);
                waited++;
            end
            if (!s_tready) begin
                checkOutput("handshake_timeout", 64'(s_tready), 64'd1);
                s_tvalid = 1'b0;
                return;
            end
            if (no_stall) checkOutput("no_stall", 64'(waited), 64'd0);
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic waitIdle();
        int w;
        mode = 0;
        w    = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() > 0 || m_valid != 3'b000) && w < 300) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drain_left", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] hdr;
        logic [63:0] tail;
        n_checks   = 0;
        n_errors   = 0;
        drop_exp   = 0;
        mode       = 0;
        mon_en     = 1'b0;
        drop_watch = 1'b0;
        cur_tgt    = 2'd0;
        rst        = 1'b1;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tkeep    = '0;
        s_tlast    = 1'b0;

        @(negedge clk);
        checkOutput("rst_valid", 64'(m_valid), 64'd0);
        for (int n = 0; n < 3; n++)
            checkOutput($sformatf("rst_fifo%0d_reg", n), m_beat[n].d | 64'(m_beat[n].k) | 64'(m_beat[n].l), 64'd0);
        checkOutput("rst_drop_count", 64'(drop_count), 64'd0);
        checkOutput("rst_s_ready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        $display("[TB] 4-beat prio1 packet, all outputs ready");
        applyStimulus(2'd1, 4, 0, 1'b1);
        waitIdle();

        $display("[TB] 3-beat prio0 packet against a stalled fifo0");
        mode = 2;
        fork
            applyStimulus(2'd0, 3, 0, 1'b0);
            begin
                int w;
                w = 0;
                while (!m_valid[0] && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stall_s_ready", 64'(s_tready), 64'd0);
                end
                mode = 0;
            end
        join
        waitIdle();

        $display("[TB] back-to-back single-beat packets 2,0,1,3,2");
        applyStimulus(2'd2, 1, 0, 1'b1);
        applyStimulus(2'd0, 1, 0, 1'b1);
        applyStimulus(2'd1, 1, 0, 1'b1);
        applyStimulus(2'd3, 1, 0, 1'b1);
        applyStimulus(2'd2, 1, 0, 1'b1);
        waitIdle();
        checkOutput("b2b_drop_count", 64'(drop_count), 64'(drop_exp));

        $display("[TB] fifo0 blocked does not block fifo2");
        mode = 2;
        applyStimulus(2'd0, 1, 0, 1'b0);
        applyStimulus(2'd2, 2, 0, 1'b1);
        fork
            applyStimulus(2'd0, 2, 0, 1'b0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("prio0_blocked", 64'(s_tready), 64'd0);
                end
                mode = 0;
            end
        join
        waitIdle();

        $display("[TB] 5-beat dropped packet");
        repeat (2) @(negedge clk);
        drop_watch = 1'b1;
        applyStimulus(2'd3, 5, 0, 1'b1);
        @(negedge clk);
        drop_watch = 1'b0;
        checkOutput("drop5_count", 64'(drop_count), 64'(drop_exp));
        @(posedge clk);
        #1;

        $display("[TB] random packets with random downstream readiness");
        mode = 1;
        for (int i = 0; i < 40; i++)
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 2, 1'b0);
        waitIdle();
        checkOutput("random_drop_count", 64'(drop_count), 64'(drop_exp));

        $display("[TB] drive the drop counter into saturation");
        for (int i = 0; i < 20; i++)
            applyStimulus(2'd3, int'($urandom_range(1, 2)), 0, 1'b1);
        waitIdle();
        checkOutput("sat_drop_count", 64'(drop_count), 64'(drop_exp));

        $display("[TB] reset in the middle of a 4-beat prio1 packet");
        mon_en   = 1'b0;
        hdr      = {$urandom, $urandom};
        hdr[1:0] = 2'd1;
        s_tdata  = hdr;
        s_tkeep  = 8'hff;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tdata = {$urandom, $urandom};
        @(posedge clk);
        #1;
        s_tdata = {$urandom, $urandom};
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_m1_valid", 64'(m1_tvalid), 64'd0);
        checkOutput("rst_async_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        hdr      = {$urandom, $urandom};
        hdr[1:0] = 2'd2;
        s_tdata  = hdr;
        @(negedge clk);
        checkOutput("post_rst_hdr_ready", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;
        tail    = {$urandom, $urandom};
        s_tdata = tail;
        s_tlast = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_m2_valid", 64'(m2_tvalid), 64'd1);
        checkOutput("post_rst_m2_hdr", m2_tdata, hdr);
        checkOutput("post_rst_m1_idle", 64'(m1_tvalid), 64'd0);
        checkOutput("post_rst_fwd_ready", 64'(s_tready), 64'd1);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_m2_tail", m2_tdata, tail);
        checkOutput("post_rst_m2_last", 64'(m2_tlast), 64'd1);
        checkOutput("post_rst_drop_count", 64'(drop_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_priority_demux.md
Name: axis_priority_demux

Overview:
- Ingress counterpart of the 3-way strict-priority merge in the Scheduler path.
- Takes one AXI-Stream packet stream and decodes a 2-bit priority field from each packet's first beat.
- Steers the whole packet to one of three priority FIFO outputs (fifo0 is highest), or drops it.
- Each output has a registered stage. Routing is locked per packet, so a packet is never split across outputs.

Parameters:
- AXIS_DATA_WIDTH, 64, data bus width.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- PRIO_OFFSET, 0, LSB index of the 2-bit priority field in the first-beat tdata. Must satisfy PRIO_OFFSET+1 < AXIS_DATA_WIDTH.
- CNT_WIDTH, 32, width of the drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of packet
- m_axis_priority_fifoN_tdata (N=0,1,2)  out  AXIS_DATA_WIDTH  registered data per output
- m_axis_priority_fifoN_tkeep  out  AXIS_KEEP_WIDTH  registered keep
- m_axis_priority_fifoN_tvalid  out  1  registered valid
- m_axis_priority_fifoN_tready  in  1  downstream ready
- m_axis_priority_fifoN_tlast  out  1  registered last
- drop_count  out  CNT_WIDTH  count of dropped packets, saturating

Behaviour:
- Reset (async assert, sync deassert usage): all m_*_tvalid=0, m_*_tdata/tkeep/tlast=0, drop_count=0, FSM=HEAD, route register=0.
- Reset mid-packet: the partial packet is abandoned. Any output beats already registered but not yet accepted are discarded. The next input beat after reset is treated as a header.
- FSM states:
  - HEAD: waiting for first beat.
  - FWD: mid-packet, forwarding to the latched route.
  - DROP: mid-packet, discarding.
- Priority decode: prio = s_axis_tdata[PRIO_OFFSET+1:PRIO_OFFSET], sampled only in HEAD. 0 selects fifo0, 1 selects fifo1, 2 selects fifo2, 3 means drop.
- Target selection: in HEAD the target is the decoded prio; in FWD it is the latched route.
- Output register N is "free" when m_N_tvalid=0 or m_N_tready=1.
- s_axis_tready (combinational from state, tdata and the target's free signal):
  - HEAD: s_axis_tvalid && (prio==3 || target free).
  - FWD: target free.
  - DROP: 1.
- Transfer = s_axis_tvalid && s_axis_tready.
- On a transfer to output N, its register loads tdata/tkeep/tlast and sets tvalid=1 on the next edge. Input-to-output latency is 1 cycle.
- Output N: tvalid clears when m_N_tready=1 and no new load occurs. Load and drain in the same cycle keep tvalid=1 with the new beat, giving full throughput (1 beat/cycle).
- Non-target outputs are unaffected and drain independently. A stalled fifo0 does not block a packet going to fifo1.
- Transitions:
  - HEAD, transfer, prio<3, !tlast: latch route, go to FWD.
  - HEAD, transfer, prio<3, tlast: single-beat packet, stay in HEAD.
  - HEAD, transfer, prio==3: drop_count+=1 (saturates at all-ones). Stay in HEAD if tlast, else go to DROP.
  - FWD, transfer with tlast: go to HEAD.
  - DROP, transfer with tlast: go to HEAD.
- Dropped beats never assert any m_*_tvalid. The drop is counted on the header beat.
- The header beat is forwarded unmodified; the priority field is not stripped.
- tkeep is passed through and not checked. A tlast beat with tkeep=0 is forwarded as-is.
- No combinational path from s_axis_tvalid/tdata to any m_* output. The only combinational path is m_N_tready to s_axis_tready.
- AXIS rules: outputs hold tdata/tkeep/tlast stable while tvalid=1 and tready=0. s_axis_tready must not depend on s_axis_tvalid outside HEAD.

Test Plan:
- Reset, then a 4-beat packet with prio=1 in beat 0 and all m_tready=1 -> fifo1 shows 4 beats on consecutive cycles, 1 cycle after input, tlast on beat 4. fifo0/fifo2 tvalid stay 0.
- 3-beat prio=0 packet with m0_tready held 0 for 5 cycles -> 1st beat is registered, s_axis_tready=0 while m0_tvalid=1 and m0_tready=0, m0_tdata stable. Release: remaining beats follow, 3 total, no loss or duplication.
- Back-to-back single-beat packets with prio 2, 0, 1, 3, 2 -> fifo2 gets 2 beats, fifo0 1, fifo1 1, drop_count=1, zero bubbles on the input.
- m0_tready=0 with fifo0 occupied, then a prio=2 packet -> it flows to fifo2 unblocked. A following prio=0 packet stalls until m0_tready=1.
- 5-beat prio=3 packet -> s_axis_tready=1 for all 5 beats, no m_*_tvalid, drop_count increments by 1 on beat 0. Preload drop_count near saturation via a long run: it sticks at 2^CNT_WIDTH-1.
- Assert rst during beat 2 of a 4-beat prio=1 packet -> m1_tvalid=0 immediately (async). After release, beat 3 is decoded as a header (tdata[1:0] sets the route); drop_count=0.
